uart_rx_frame: RTL and testbench
================================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame (LSB first).
REQ-002 Parameter PRESCALE_W, default 6, width of Prescale input.
REQ-003 CLK  input  1  oversampling clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 RX_IN  input  1  serial line, idle high; pre-synchronised externally.
REQ-006 PAR_EN  input  1  1 = frame carries parity bit after data.
REQ-007 PAR_TYP  input  1  1 = even parity (XOR of data), 0 = odd parity (XNOR of data), matching TX generator.
REQ-008 Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-009 P_DATA  output  DATA_WIDTH  received data word.
REQ-010 data_valid  output  1  one-cycle pulse, P_DATA valid and error-free.
REQ-011 par_err  output  1  parity mismatch flag for current frame.
REQ-012 stp_err  output  1  stop bit sampled low flag for current frame.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-014 Edge counter SHALL count 0..Prescale-1 per bit, wrap to 0 and increment bit counter on Prescale-1.
REQ-015 Each bit SHALL be majority-voted from samples at edge counts Prescale/2-1, Prescale/2, Prescale/2+1; vote registered at count Prescale/2+2.
REQ-016 IDLE->START on RX_IN low sampled in IDLE; edge counter cleared.
REQ-017 START: voted bit high (glitch) -> IDLE, no outputs asserted; voted low -> DATA at end of bit.
REQ-018 DATA: shift voted bit into P_DATA LSB first; after DATA_WIDTH bits -> PARITY if PAR_EN else STOP.
REQ-019 PARITY: par_err SHALL be set at vote if voted bit differs from expected parity per REQ-007; -> STOP at end of bit.
REQ-020 STOP: stp_err SHALL be set at vote if voted bit is 0; state -> DONE at vote cycle (half-bit early, allows back-to-back frames).
REQ-021 DONE: data_valid SHALL pulse exactly one cycle iff par_err=0 and stp_err=0; then -> IDLE, or directly START if RX_IN low.
REQ-022 par_err/stp_err SHALL hold until next frame's START state is entered, then clear.
REQ-023 P_DATA SHALL be stable from data_valid until next frame's first DATA bit shifts in.
REQ-024 PAR_EN, PAR_TYP, Prescale SHALL be sampled only in IDLE; changes mid-frame have no effect on current frame.
REQ-025 Latency: data_valid asserts 2 cycles after stop-bit middle sample (Prescale/2+1).
REQ-026 Illegal Prescale values SHALL behave as 8.

Reset
REQ-027 On RST low: state IDLE, counters 0, P_DATA 0, data_valid 0, par_err 0, stp_err 0, immediately and asynchronously.
REQ-028 Reset mid-frame SHALL abort frame with no data_valid; first falling edge after release starts a fresh frame.

Structure
REQ-029 Shared package SHALL hold FSM state encoding, legal Prescale constants, and parity-type encoding shared with TX.
REQ-030 One sub-module SHALL be natural: uart_rx_sampler (edge counter + 3-sample majority vote), all else in uart_rx_frame.

Verification
REQ-031 Prescale=8, PAR_EN=0, frame 0x A5 -> P_DATA=0xA5, data_valid one pulse, par_err=stp_err=0.
REQ-032 Prescale=16, PAR_EN=1, PAR_TYP=1, data 0x07 with parity bit 0 -> par_err=1, no data_valid.
REQ-033 Prescale=32, stop bit driven 0, data 0x3C -> stp_err=1, no data_valid, P_DATA=0x3C.
REQ-034 Start-bit glitch low for 2 clocks at Prescale=16 -> return to IDLE, no flags, no data_valid.
REQ-035 Two back-to-back frames 0x55 then 0xAA, single stop bit, Prescale=8 -> two data_valid pulses, correct words.
REQ-036 RST asserted during DATA bit 4 -> all outputs 0 at once; next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// ============================================================================
// Module      : uart_rx_frame_pkg
// Description : Shared types and constants for the UART receive frame path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Parity-type encoding shared with the transmitter
    localparam logic PAR_TYP_ODD  = 1'b0;
    localparam logic PAR_TYP_EVEN = 1'b1;

    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_TYP_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit edge counter with three-sample majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rx,
    input  logic                  i_clear,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_bit_done,
    output logic                  o_vote_strobe,
    output logic                  o_vote_bit
);

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [2:0]            r_samples;

    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_last;
    logic [PRESCALE_W-1:0] w_s0_pos;
    logic [PRESCALE_W-1:0] w_s2_pos;
    logic [PRESCALE_W-1:0] w_vote_pos;

    assign w_half     = i_prescale >> 1;
    assign w_last     = i_prescale - PRESCALE_W'(1);
    assign w_s0_pos   = w_half - PRESCALE_W'(1);
    assign w_s2_pos   = w_half + PRESCALE_W'(1);
    assign w_vote_pos = w_half + PRESCALE_W'(2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_samples  <= '0;
        end else if (i_clear) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= (r_edge_cnt == w_last) ? '0 : r_edge_cnt + PRESCALE_W'(1);
            if (r_edge_cnt == w_s0_pos) r_samples[0] <= i_rx;
            if (r_edge_cnt == w_half)   r_samples[1] <= i_rx;
            if (r_edge_cnt == w_s2_pos) r_samples[2] <= i_rx;
        end
    end

    // All three samples are already registered when the vote position is reached
    assign o_bit_done    = !i_clear && (r_edge_cnt == w_last);
    assign o_vote_strobe = !i_clear && (r_edge_cnt == w_vote_pos);
    assign o_vote_bit    = (r_samples[0] & r_samples[1]) |
                           (r_samples[0] & r_samples[2]) |
                           (r_samples[1] & r_samples[2]);

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module      : uart_rx_frame
// Description : UART frame receiver with optional parity and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    import uart_rx_frame_pkg::*;

    localparam int                    c_BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0]  c_PS8      = PRESCALE_W'(PRESCALE_8);
    localparam logic [PRESCALE_W-1:0]  c_PS16     = PRESCALE_W'(PRESCALE_16);
    localparam logic [PRESCALE_W-1:0]  c_PS32     = PRESCALE_W'(PRESCALE_32);

    rx_state_t r_state;
    rx_state_t w_state_next;

    logic [PRESCALE_W-1:0]  r_prescale;
    logic                   r_par_en;
    logic                   r_par_typ;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic                   r_valid;
    logic                   r_par_err;
    logic                   r_stp_err;

    logic                   w_prescale_legal;
    logic                   w_clear;
    logic                   w_bit_done;
    logic                   w_vote_strobe;
    logic                   w_vote_bit;
    logic                   w_enter_start;

    assign w_prescale_legal = (Prescale == c_PS8) || (Prescale == c_PS16) || (Prescale == c_PS32);
    assign w_clear          = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_enter_start    = (w_state_next == ST_START) && (r_state != ST_START);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk           (CLK),
        .rst_n         (RST),
        .i_rx          (RX_IN),
        .i_clear       (w_clear),
        .i_prescale    (r_prescale),
        .o_bit_done    (w_bit_done),
        .o_vote_strobe (w_vote_strobe),
        .o_vote_bit    (w_vote_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_vote_strobe && w_vote_bit) w_state_next = ST_IDLE;
                else if (w_bit_done)             w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_done && (r_bit_cnt == c_LAST_BIT))
                    w_state_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_done) w_state_next = ST_STOP;
            end
            // Leave at the stop-bit vote so a following start edge is not missed
            ST_STOP: begin
                if (w_vote_strobe) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_state_next = RX_IN ? ST_IDLE : ST_START;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prescale <= c_PS8;
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_TYP_ODD;
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_prescale <= w_prescale_legal ? Prescale : c_PS8;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
            end

            if (w_enter_start) begin
                r_par_err <= 1'b0;
                r_stp_err <= 1'b0;
            end

            if (r_state == ST_DATA) begin
                if (w_bit_done) r_bit_cnt <= r_bit_cnt + c_BIT_CNT_W'(1);
            end else begin
                r_bit_cnt <= '0;
            end

            if (w_vote_strobe) begin
                case (r_state)
                    ST_DATA:   r_data    <= {w_vote_bit, r_data[DATA_WIDTH-1:1]};
                    ST_PARITY: r_par_err <= (w_vote_bit != expected_parity(^r_data, r_par_typ));
                    ST_STOP: begin
                        r_stp_err <= ~w_vote_bit;
                        r_valid   <= w_vote_bit & ~r_par_err;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = r_data;
    assign data_valid = r_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module      : tb_uart_rx_frame
// Description : Scoreboard-driven bench for the UART frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b0;
    logic          RX_IN   = 1'b1;
    logic          PAR_EN  = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [PW-1:0] Prescale = 6'd8;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int            n_vec = 0;
    int            n_err = 0;
    int            pulses = 0;
    bit            seen_par = 1'b0;
    bit            seen_stp = 1'b0;
    logic [DW-1:0] sb[$];

    always #5 CLK = ~CLK;

    uart_rx_frame #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    // Advance one clock, sample just after the edge, retire scoreboard entries on data_valid
    task automatic tick();
        logic [DW-1:0] exp_d;
        @(posedge CLK);
        #1;
        if (data_valid === 1'b1) begin
            pulses++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_valid: got P_DATA=%h, required no data_valid", P_DATA);
            end else begin
                exp_d = sb.pop_front();
                if (P_DATA !== exp_d) begin
                    n_err++;
                    $display("FAIL sb_data: got %h, required %h", P_DATA, exp_d);
                end
            end
        end
        if (par_err === 1'b1) seen_par = 1'b1;
        if (stp_err === 1'b1) seen_stp = 1'b1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        repeat (n) tick();
    endtask

    task automatic configure(input int p, input logic pe, input logic pt);
        Prescale = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pe,
                              input logic pt, input logic bad_par, input logic stop_bit);
        logic pb;
        pulses   = 0;
        seen_par = 1'b0;
        seen_stp = 1'b0;
        if (!(pe && bad_par) && stop_bit) sb.push_back(d);
        drive_bit(1'b0, p);
        for (int i = 0; i < DW; i++) drive_bit(d[i], p);
        if (pe) begin
            pb = pt ? ^d : ~^d;
            if (bad_par) pb = ~pb;
            drive_bit(pb, p);
        end
        drive_bit(stop_bit, p);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_vec++; if (P_DATA !== '0)     begin n_err++; $display("FAIL reset_pdata: got %h, required 00", P_DATA); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", data_valid); end
        n_vec++; if (par_err !== 1'b0)  begin n_err++; $display("FAIL reset_par: got %b, required 0", par_err); end
        n_vec++; if (stp_err !== 1'b0)  begin n_err++; $display("FAIL reset_stp: got %b, required 0", stp_err); end
        RST = 1'b1;
        drive_bit(1'b1, 4);
    endtask

    task automatic test_basic();
        configure(8, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        n_vec++; if (pulses != 1)   begin n_err++; $display("FAIL basic_pulses: got %0d, required 1", pulses); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL basic_pending: got %0d, required 0", sb.size()); end
        n_vec++; if (seen_par || seen_stp) begin n_err++; $display("FAIL basic_flags: got par=%b stp=%b, required 0 0", seen_par, seen_stp); end
    endtask

    task automatic test_parity();
        configure(16, 1'b1, 1'b1);
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 16);
        n_vec++; if (pulses != 0)     begin n_err++; $display("FAIL par_pulses: got %0d, required 0", pulses); end
        n_vec++; if (par_err !== 1'b1) begin n_err++; $display("FAIL par_flag: got %b, required 1", par_err); end
        n_vec++; if (seen_stp)        begin n_err++; $display("FAIL par_stp: got 1, required 0"); end
        configure(16, 1'b1, 1'b0);
        send_frame(8'h3B, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 16);
        n_vec++; if (pulses != 1)     begin n_err++; $display("FAIL par_odd_pulses: got %0d, required 1", pulses); end
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_odd_flag: got %b, required 0", par_err); end
    endtask

    task automatic test_stop_err();
        configure(32, 1'b0, 1'b0);
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b1, 40);
        n_vec++; if (pulses != 0)      begin n_err++; $display("FAIL stp_pulses: got %0d, required 0", pulses); end
        n_vec++; if (!seen_stp)        begin n_err++; $display("FAIL stp_flag: got 0, required 1"); end
        n_vec++; if (seen_par)         begin n_err++; $display("FAIL stp_par: got 1, required 0"); end
        n_vec++; if (P_DATA !== 8'h3C) begin n_err++; $display("FAIL stp_pdata: got %h, required 3c", P_DATA); end
    endtask

    task automatic test_glitch();
        configure(16, 1'b0, 1'b0);
        pulses   = 0;
        seen_par = 1'b0;
        seen_stp = 1'b0;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 48);
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL glitch_pulses: got %0d, required 0", pulses); end
        n_vec++; if (par_err !== 1'b0 || stp_err !== 1'b0)
            begin n_err++; $display("FAIL glitch_flags: got par=%b stp=%b, required 0 0", par_err, stp_err); end
        send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 16);
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL glitch_recover: got %0d, required 1", pulses); end
    endtask

    task automatic test_back_to_back();
        configure(8, 1'b0, 1'b0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL b2b_first: got %0d, required 1", pulses); end
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        n_vec++; if (pulses != 1)    begin n_err++; $display("FAIL b2b_second: got %0d, required 1", pulses); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_cfg_lock();
        logic [DW-1:0] d;
        d = 8'hC3;
        configure(8, 1'b0, 1'b0);
        pulses = 0;
        sb.push_back(d);
        drive_bit(1'b0, 8);
        configure(16, 1'b1, 1'b1);
        for (int i = 0; i < DW; i++) drive_bit(d[i], 8);
        drive_bit(1'b1, 16);
        n_vec++; if (pulses != 1)     begin n_err++; $display("FAIL cfg_lock_pulses: got %0d, required 1", pulses); end
        n_vec++; if (par_err !== 1'b0) begin n_err++; $display("FAIL cfg_lock_par: got %b, required 0", par_err); end
    endtask

    task automatic test_illegal_prescale();
        configure(12, 1'b0, 1'b0);
        drive_bit(1'b1, 4);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL illegal_ps_pulses: got %0d, required 1", pulses); end
    endtask

    task automatic test_reset_midframe();
        configure(8, 1'b0, 1'b0);
        pulses = 0;
        drive_bit(1'b0, 8);
        repeat (4) drive_bit(1'b1, 8);
        drive_bit(1'b1, 4);
        n_vec++; if (P_DATA[7:4] !== 4'hF) begin n_err++; $display("FAIL mid_shift: got %h, required f in upper nibble", P_DATA); end
        #2;
        RST = 1'b0;
        #1;
        n_vec++; if (P_DATA !== '0 || data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0)
            begin n_err++; $display("FAIL mid_async_clear: got pdata=%h dv=%b par=%b stp=%b, required all 0", P_DATA, data_valid, par_err, stp_err); end
        RX_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b1;
        drive_bit(1'b1, 8);
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL mid_no_valid: got %0d, required 0", pulses); end
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 8);
        n_vec++; if (pulses != 1)    begin n_err++; $display("FAIL mid_next_frame: got %0d, required 1", pulses); end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL mid_pending: got %0d, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_cfg_lock();
        test_illegal_prescale();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
